// File: rtl/cle_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cle_pkg : shared image geometry, SRAM/ROM widths and packer state encoding.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package cle_pkg;

  localparam int CLE_IMG_W       = 32;
  localparam int CLE_IMG_H       = 32;
  localparam int CLE_ADDR_W      = 10;
  localparam int CLE_PIX_W       = 8;
  localparam int CLE_ROM_W       = 8;
  localparam int PIX_PER_BYTE    = 8;
  localparam int BYTES_PER_FRAME = CLE_IMG_W * CLE_IMG_H / PIX_PER_BYTE;
  localparam int CLE_ROM_DEPTH   = BYTES_PER_FRAME;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } cle_state_e;

  // Any non-zero label marks a foreground pixel.
  function automatic logic label_bit(input logic [CLE_PIX_W-1:0] label);
    return |label;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cle_pix_shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cle_pix_shift : MSB-first pixel capture register with load count.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module cle_pix_shift (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] byte_nxt,
  output logic       last_bit
);

  // The eighth bit is never stored: it is presented straight on byte_nxt.
  logic [6:0] sh_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sh_q  <= {sh_q[5:0], bit_in};
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign byte_nxt = {sh_q, bit_in};
  assign last_bit = (cnt_q == 3'd7);

endmodule
`default_nettype wire

// File: rtl/cle_label_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cle_label_packer : reads the CLE label map back from SRAM and streams it as
// the packed 1-bit-per-pixel bitmap. CLE_LABEL_STAT_EN adds obj_cnt/pix_cnt.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module cle_label_packer
  import cle_pkg::*;
#(
  parameter int IMG_W     = CLE_IMG_W,
  parameter int IMG_H     = CLE_IMG_H,
  parameter int ADDR_W    = CLE_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic [ADDR_W-1:0]                   sram_a,
  input  logic [7:0]                          sram_q,
  output logic                                sram_wen,
  output logic [7:0]                          out_data,
  output logic [$clog2(IMG_W*IMG_H/8)-1:0]    out_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
`ifdef CLE_LABEL_STAT_EN
  ,
  output logic [7:0]                          obj_cnt,
  output logic [10:0]                         pix_cnt
`endif
);

  localparam int                 BYTES     = IMG_W * IMG_H / 8;
  localparam int                 IDX_W     = $clog2(BYTES);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0]  BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(BASE_ADDR + IMG_W * IMG_H - 1);

  cle_state_e         state_q;
  logic [ADDR_W-1:0]  sram_a_q;
  logic               prime_q;
  logic [IDX_W-1:0]   byte_cnt_q;
  logic [7:0]         out_data_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               busy_q;
  logic               done_q;

  logic [ADDR_W-1:0]  addr_d;
  logic               pix_bit;
  logic               start_acc;
  logic               capture;
  logic [7:0]         byte_nxt;
  logic               last_bit;

  assign addr_d    = (sram_a_q == LAST_ADDR) ? BASE_A : sram_a_q + ADDR_W'(1);
  assign pix_bit   = label_bit(sram_q);
  assign start_acc = (state_q == IDLE) && start;
  // The first FETCH cycle after start only primes the SRAM read pipeline.
  assign capture   = (state_q == FETCH) && !prime_q;

  cle_pix_shift u_shift (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_acc),
    .shift_en (capture),
    .bit_in   (pix_bit),
    .byte_nxt (byte_nxt),
    .last_bit (last_bit)
  );

  // sram_a already points at the next byte's first pixel while a byte waits in
  // EMIT, so the handshake advances it and capture resumes on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sram_a_q    <= BASE_A;
      prime_q     <= 1'b0;
      byte_cnt_q  <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            prime_q    <= 1'b1;
            busy_q     <= 1'b1;
            byte_cnt_q <= '0;
          end
        end
        FETCH: begin
          prime_q <= 1'b0;
          if (!last_bit) begin
            sram_a_q <= addr_d;
          end
          if (capture && last_bit) begin
            state_q     <= EMIT;
            out_data_q  <= byte_nxt;
            out_idx_q   <= byte_cnt_q;
            out_last_q  <= (byte_cnt_q == LAST_IDX);
            out_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= FETCH;
              sram_a_q   <= addr_d;
              byte_cnt_q <= byte_cnt_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sram_a    = sram_a_q;
  assign sram_wen  = 1'b1;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CLE_LABEL_STAT_EN
  logic [255:0] seen_q;
  logic [7:0]   obj_cnt_q;
  logic [10:0]  pix_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q    <= '0;
      obj_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else if (start_acc) begin
      seen_q    <= '0;
      obj_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else if (capture && pix_bit) begin
      pix_cnt_q <= pix_cnt_q + 11'd1;
      if (!seen_q[sram_q]) begin
        seen_q[sram_q] <= 1'b1;
        obj_cnt_q      <= obj_cnt_q + 8'd1;
      end
    end
  end

  assign obj_cnt = obj_cnt_q;
  assign pix_cnt = pix_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cle_label_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cle_label_packer : self-checking bench for the label map packer.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_cle_label_packer;

  localparam int NB     = 128;
  localparam int NPIX   = 1024;
  localparam int BUDGET = 3000;
  // start sampled at E0: first byte valid at E9, handshake E10, then every 9 edges
  localparam int FIRST_VLD = 9;
  localparam int DONE_LAT  = 10 + (NB - 1) * 9;
  localparam int RESET_VEC = int'({10'd0, 1'b1, 19'd0});

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  sram_a;
  logic [7:0]  sram_q;
  logic        sram_wen;
  logic [7:0]  out_data;
  logic [6:0]  out_idx;
  logic        out_valid, out_last, busy, done;
`ifdef CLE_LABEL_STAT_EN
  logic [7:0]  obj_cnt;
  logic [10:0] pix_cnt;
`endif

  logic [7:0] mem     [NPIX];
  logic [7:0] exp_img [NB];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  cle_label_packer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .sram_wen  (sram_wen),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef CLE_LABEL_STAT_EN
    ,
    .obj_cnt   (obj_cnt),
    .pix_cnt   (pix_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sram_q <= mem[sram_a];
  end

  // Handshake monitor
  logic [7:0] q_data [$];
  int         q_idx  [$];
  bit         q_last [$];
  int         q_hs   [$];
  bit mon_en = 1'b0;
  bit vld_prev = 1'b0;
  int done_cnt, done_cyc, first_vld, bad_vld;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_idx.push_back(int'(out_idx));
        q_last.push_back(out_last);
        q_hs.push_back(cyc + 1);
      end
      if (out_valid && !vld_prev && first_vld < 0) first_vld = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && !busy) bad_vld++;
      vld_prev = out_valid;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  function automatic int out_vec();
    return int'({sram_a, sram_wen, out_data, out_idx, out_valid, out_last, busy, done});
  endfunction

  // Expected stream straight from the bitmap rule: bit(7-j) of byte k is pixel 8k+j != 0.
  task automatic build_expect();
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++)
        exp_img[k][7-j] = (mem[8*k+j] != 8'h00);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
  endtask

`ifdef CLE_LABEL_STAT_EN
  task automatic check_stats(input string tag);
    int seen [int];
    int pix = 0;
    foreach (mem[i]) if (mem[i] != 8'h00) begin
      pix++;
      seen[int'(mem[i])] = 1;
    end
    check({tag, "_obj_cnt"}, int'(obj_cnt), seen.num());
    check({tag, "_pix_cnt"}, int'(pix_cnt), pix);
  endtask
`endif

  task automatic do_stall(input int k);
    int n = 0;
    bit ok = 1'b1;
    logic [7:0] d0;
    logic [6:0] i0;
    logic [9:0] a0;
    while (!(out_valid && int'(out_idx) == k - 1) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_byte_present", int'(out_valid), 1);
    check("stall_byte_idx", int'(out_idx), k);
    d0 = out_data;
    i0 = out_idx;
    a0 = sram_a;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== d0 || out_idx !== i0 || sram_a !== a0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("stall_outputs_stable", int'(ok), 1);
    out_ready = 1'b1;
  endtask

  task automatic run_frame(input int stall_idx, input int restart_idx,
                           input bit start_in_done, output int s);
    q_data.delete(); q_idx.delete(); q_last.delete(); q_hs.delete();
    done_cnt = 0; done_cyc = -1; first_vld = -1; bad_vld = 0; vld_prev = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    s = cyc;
    fork
      begin : p_done
        int n;
        n = 0;
        while (!done && n < BUDGET) begin
          @(negedge clk);
          n++;
        end
        check("frame_done_seen", int'(done), 1);
        if (done && start_in_done) begin
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
      begin : p_stall
        if (stall_idx >= 0) do_stall(stall_idx);
      end
      begin : p_restart
        int n;
        n = 0;
        if (restart_idx >= 0) begin
          while (!(out_valid && int'(out_idx) == restart_idx) && n < BUDGET) begin
            @(negedge clk);
            n++;
          end
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic verify_frame(input string tag, input int s, input bit timing);
    int bad_d = 0, bad_i = 0, bad_l = 0, bad_h = 0, first = -1;
    check({tag, "_byte_count"}, q_data.size(), NB);
    for (int i = 0; i < q_data.size() && i < NB; i++) begin
      if (q_data[i] !== exp_img[i]) begin
        bad_d++;
        if (first < 0) first = i;
      end
      if (q_idx[i] != i) bad_i++;
      if (q_last[i] != (i == NB - 1)) bad_l++;
      if (i > 0 && q_hs[i] - q_hs[i-1] != 9) bad_h++;
    end
    if (first >= 0)
      $display("  %s: first differing byte %0d got 0x%0h want 0x%0h", tag, first, q_data[first], exp_img[first]);
    check({tag, "_data_errors"}, bad_d, 0);
    check({tag, "_idx_errors"}, bad_i, 0);
    check({tag, "_last_errors"}, bad_l, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_valid_outside_busy"}, bad_vld, 0);
    check({tag, "_addr_back_to_base"}, int'(sram_a), 0);
    check({tag, "_idle_after"}, int'({busy, out_valid, done, sram_wen}), 1);
    if (timing) begin
      check({tag, "_first_valid_latency"}, first_vld - s, FIRST_VLD);
      check({tag, "_done_latency"}, done_cyc - s, DONE_LAT);
      check({tag, "_handshake_spacing_errors"}, bad_h, 0);
    end
  endtask

  typedef struct {
    int         addr;
    logic [7:0] label;
    int         idx;
    logic [7:0] byt;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int s, n, others, got;
    logic [7:0] src [NB];

    tbl[0] = '{0,    8'h01, 0,   8'h80};
    tbl[1] = '{7,    8'h03, 0,   8'h01};
    tbl[2] = '{1023, 8'h02, 127, 8'h01};
    tbl[3] = '{8,    8'hFF, 1,   8'h80};
    tbl[4] = '{37,   8'h80, 4,   8'h04};
    tbl[5] = '{500,  8'h7F, 62,  8'h08};

    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), RESET_VEC);
`ifdef CLE_LABEL_STAT_EN
    check("reset_stats", int'({obj_cnt, pix_cnt}), 0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero frame with full timing
    build_expect();
    run_frame(-1, -1, 1'b0, s);
    verify_frame("zero", s, 1'b1);

    // Single-label placement table
    foreach (tbl[t]) begin
      clear_mem();
      mem[tbl[t].addr] = tbl[t].label;
      run_frame(-1, -1, 1'b0, s);
      check($sformatf("tbl%0d_count", t), q_data.size(), NB);
      got = (q_data.size() > tbl[t].idx) ? int'(q_data[tbl[t].idx]) : -1;
      check($sformatf("tbl%0d_byte", t), got, int'(tbl[t].byt));
      others = 0;
      for (int i = 0; i < q_data.size(); i++)
        if (i != tbl[t].idx && q_data[i] != 8'h00) others++;
      check($sformatf("tbl%0d_other_nonzero", t), others, 0);
    end

    // Three labels at the frame corners
    clear_mem();
    mem[0] = 8'h01; mem[7] = 8'h03; mem[1023] = 8'h02;
    build_expect();
    run_frame(-1, -1, 1'b0, s);
    verify_frame("corners", s, 1'b1);
    check("corners_byte0", (q_data.size() > 0) ? int'(q_data[0]) : -1, 8'h81);
    check("corners_byte127", (q_data.size() > 127) ? int'(q_data[127]) : -1, 8'h01);
`ifdef CLE_LABEL_STAT_EN
    check_stats("corners");
`endif

    // Round trip: random source bitmap labelled with random component ids
    for (int k = 0; k < NB; k++) begin
      src[k] = 8'($urandom);
      for (int j = 0; j < 8; j++)
        mem[8*k+j] = src[k][7-j] ? 8'($urandom_range(1, 255)) : 8'h00;
    end
    mem[3] = 8'hFF;
    src[0][4] = 1'b1;
    exp_img = src;
    run_frame(-1, -1, 1'b0, s);
    verify_frame("roundtrip", s, 1'b1);
`ifdef CLE_LABEL_STAT_EN
    check_stats("roundtrip");
`endif

    // Random map with a 20-cycle stall on byte 5
    for (int i = 0; i < NPIX; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
    build_expect();
    run_frame(5, -1, 1'b0, s);
    verify_frame("stall", s, 1'b0);
    check("stall_next_byte_gap", (q_hs.size() > 6) ? q_hs[6] - q_hs[5] : -1, 9);

    // start while busy and during the DONE cycle is ignored; next start runs a fresh frame
    run_frame(-1, 40, 1'b1, s);
    verify_frame("restart_busy", s, 1'b1);
    run_frame(-1, -1, 1'b0, s);
    verify_frame("start_after_done", s, 1'b1);

    // Reset during the FETCH of byte 60
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    build_expect();
    @(posedge clk);
    #1 start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 7'd59) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reached_byte59", int'(out_idx), 59);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_outputs", out_vec(), RESET_VEC);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_stays_idle", int'({busy, out_valid, done}), 0);
    run_frame(-1, -1, 1'b0, s);
    verify_frame("after_reset", s, 1'b1);
`ifdef CLE_LABEL_STAT_EN
    check_stats("after_reset");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
